// File: rtl/record_play_sequencer.sv
// Beat-synchronous record/playback sequencer for the 64x32 guitar note RAM.
// Optional build macro LOOP_PLAY_EN: playback wraps to index 0 instead of stopping after one pass.
module record_play_sequencer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        select,
  input  logic        back,
  input  logic        mode,
  input  logic        beat_tick,
  input  logic [31:0] note_in,
  input  logic [31:0] ram_q,
  output logic [5:0]  ram_address,
  output logic        ram_wren,
  output logic [31:0] ram_data,
  output logic [31:0] note_out,
  output logic        note_valid,
  output logic [6:0]  length,
  output logic        recording,
  output logic        playing
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RECORDING, S_PLAYING} state_t;

  state_t      r_state, w_state_next;
  logic        r_sel_d, r_back_d;
  logic [5:0]  r_wptr, w_wptr_next;
  logic [5:0]  r_rptr, w_rptr_next;
  logic [31:0] r_acc, w_acc_next;
  logic        r_rd_pend, w_rd_pend_next;
  logic        r_rd_cap, w_rd_cap_next;
  logic        r_last_pend, w_last_pend_next;
  logic        r_last_cap, w_last_cap_next;
  logic [5:0]  r_ram_address, w_addr_next;
  logic        r_ram_wren, w_wren_next;
  logic [31:0] r_ram_data, w_data_next;
  logic [31:0] r_note_out, w_note_next;
  logic        r_note_valid, w_valid_next;
  logic [6:0]  r_length, w_len_next;
  logic        r_recording, r_playing;
  logic        w_sel_edge, w_back_edge, w_last_read;

  assign w_sel_edge  = select & ~r_sel_d;
  assign w_back_edge = back & ~r_back_d;
  assign w_last_read = (({1'b0, r_rptr} + 7'd1) == r_length);

  always_comb begin
    w_state_next     = r_state;
    w_wptr_next      = r_wptr;
    w_rptr_next      = r_rptr;
    w_acc_next       = r_acc;
    w_rd_pend_next   = 1'b0;
    w_rd_cap_next    = r_rd_pend;
    w_last_pend_next = 1'b0;
    w_last_cap_next  = r_last_pend;
    w_addr_next      = r_ram_address;
    w_wren_next      = 1'b0;
    w_data_next      = r_ram_data;
    w_note_next      = r_note_out;
    w_valid_next     = 1'b0;
    w_len_next       = r_length;

    case (r_state)
      S_IDLE: begin
        w_addr_next = 6'd0;
        if (w_sel_edge) begin
          if (!mode) begin
            w_state_next = S_ARMED;
          end else if (r_length != 7'd0) begin
            w_state_next = S_PLAYING;
            w_rptr_next  = 6'd0;
          end
        end
      end

      S_ARMED: begin
        if (w_back_edge) begin
          w_state_next = S_IDLE;
        end else if (w_sel_edge) begin
          w_state_next = S_RECORDING;
          w_wptr_next  = 6'd0;
          w_acc_next   = 32'd0;
          w_len_next   = 7'd0;
        end
      end

      S_RECORDING: begin
        w_acc_next = r_acc | note_in;
        if (w_back_edge) begin
          w_state_next = S_IDLE;
          w_len_next   = 7'd0;
          w_acc_next   = 32'd0;
        end else if (beat_tick) begin
          // A select in the same cycle still lets this beat's word land.
          w_wren_next = 1'b1;
          w_addr_next = r_wptr;
          w_data_next = r_acc | note_in;
          w_acc_next  = 32'd0;
          w_wptr_next = r_wptr + 6'd1;
          w_len_next  = r_length + 7'd1;
          if (r_wptr == 6'd63 || w_sel_edge) begin
            w_state_next = S_IDLE;
          end
        end else if (w_sel_edge) begin
          w_state_next = S_IDLE;
          w_acc_next   = 32'd0;
        end
      end

      S_PLAYING: begin
        if (w_sel_edge || w_back_edge) begin
          // Abort drops any read still in flight.
          w_state_next    = S_IDLE;
          w_rd_cap_next   = 1'b0;
          w_last_cap_next = 1'b0;
        end else begin
          if (r_rd_cap) begin
            w_note_next  = ram_q;
            w_valid_next = 1'b1;
            if (r_last_cap) begin
              w_state_next = S_IDLE;
            end
          end
          if (beat_tick && !r_last_pend && !r_last_cap) begin
            w_addr_next    = r_rptr;
            w_rd_pend_next = 1'b1;
            w_rptr_next    = r_rptr + 6'd1;
            if (w_last_read) begin
`ifdef LOOP_PLAY_EN
              w_rptr_next      = 6'd0;
`else
              w_last_pend_next = 1'b1;
`endif
            end
          end
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_sel_d       <= 1'b0;
      r_back_d      <= 1'b0;
      r_wptr        <= 6'd0;
      r_rptr        <= 6'd0;
      r_acc         <= 32'd0;
      r_rd_pend     <= 1'b0;
      r_rd_cap      <= 1'b0;
      r_last_pend   <= 1'b0;
      r_last_cap    <= 1'b0;
      r_ram_address <= 6'd0;
      r_ram_wren    <= 1'b0;
      r_ram_data    <= 32'd0;
      r_note_out    <= 32'd0;
      r_note_valid  <= 1'b0;
      r_length      <= 7'd0;
      r_recording   <= 1'b0;
      r_playing     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_sel_d       <= select;
      r_back_d      <= back;
      r_wptr        <= w_wptr_next;
      r_rptr        <= w_rptr_next;
      r_acc         <= w_acc_next;
      r_rd_pend     <= w_rd_pend_next;
      r_rd_cap      <= w_rd_cap_next;
      r_last_pend   <= w_last_pend_next;
      r_last_cap    <= w_last_cap_next;
      r_ram_address <= w_addr_next;
      r_ram_wren    <= w_wren_next;
      r_ram_data    <= w_data_next;
      r_note_out    <= w_note_next;
      r_note_valid  <= w_valid_next;
      r_length      <= w_len_next;
      r_recording   <= (w_state_next == S_ARMED) || (w_state_next == S_RECORDING);
      r_playing     <= (w_state_next == S_PLAYING);
    end
  end

  assign ram_address = r_ram_address;
  assign ram_wren    = r_ram_wren;
  assign ram_data    = r_ram_data;
  assign note_out    = r_note_out;
  assign note_valid  = r_note_valid;
  assign length      = r_length;
  assign recording   = r_recording;
  assign playing     = r_playing;

endmodule

// File: tb/tb_record_play_sequencer.sv
// Directed self-checking bench for record_play_sequencer with a registered-read RAM model.
module tb_record_play_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        select = 1'b0;
  logic        back = 1'b0;
  logic        mode = 1'b0;
  logic        beat_tick = 1'b0;
  logic [31:0] note_in = 32'd0;
  logic [31:0] ram_q = 32'd0;
  logic [5:0]  ram_address;
  logic        ram_wren;
  logic [31:0] ram_data;
  logic [31:0] note_out;
  logic        note_valid;
  logic [6:0]  length;
  logic        recording;
  logic        playing;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] mem [64];
  logic [5:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  logic [31:0] nv_data [$];

  record_play_sequencer dut (
    .clk(clk), .resetn(resetn), .select(select), .back(back), .mode(mode),
    .beat_tick(beat_tick), .note_in(note_in), .ram_q(ram_q),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data),
    .note_out(note_out), .note_valid(note_valid), .length(length),
    .recording(recording), .playing(playing)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  always @(posedge clk) begin
    if (ram_wren) begin
      wr_addr.push_back(ram_address);
      wr_data.push_back(ram_data);
      $display("write addr=%0d data=0x%08h", ram_address, ram_data);
    end
    if (note_valid) begin
      nv_data.push_back(note_out);
      $display("play  note=0x%08h", note_out);
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic press_select();
    select = 1'b1; cyc(1); select = 1'b0; cyc(1);
  endtask

  task automatic press_back();
    back = 1'b1; cyc(1); back = 1'b0; cyc(1);
  endtask

  task automatic beat(input logic [31:0] v);
    note_in = v; cyc(3);
    beat_tick = 1'b1; cyc(1);
    beat_tick = 1'b0;
  endtask

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); nv_data.delete();
  endtask

  task automatic start_recording();
    mode = 1'b0; note_in = 32'd0;
    press_select(); press_select();
  endtask

  task automatic test_reset();
    resetn = 1'b0; cyc(2);
    n_checks++; if (ram_address !== 6'd0) begin n_fail++; $display("FAIL reset_addr got=%0d want=0", ram_address); end
    n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren got=%b want=0", ram_wren); end
    n_checks++; if (note_out !== 32'd0 || note_valid !== 1'b0) begin n_fail++; $display("FAIL reset_note got=%h/%b want=0/0", note_out, note_valid); end
    n_checks++; if (length !== 7'd0 || recording !== 1'b0 || playing !== 1'b0) begin n_fail++; $display("FAIL reset_status got=%0d/%b/%b want=0/0/0", length, recording, playing); end
    resetn = 1'b1; cyc(2);
    $display("reset done");
  endtask

  task automatic test_record3();
    clear_logs();
    mode = 1'b0;
    press_select();
    n_checks++; if (recording !== 1'b1) begin n_fail++; $display("FAIL armed_recording got=%b want=1", recording); end
    press_select();
    beat(32'h1); beat(32'h40); beat(32'h0);
    note_in = 32'd0;
    press_select(); cyc(3);
    n_checks++; if (wr_addr.size() !== 3) begin n_fail++; $display("FAIL rec3_count got=%0d want=3", wr_addr.size()); end
    if (wr_addr.size() == 3) begin
      n_checks++; if (wr_addr[0] !== 6'd0 || wr_addr[1] !== 6'd1 || wr_addr[2] !== 6'd2) begin n_fail++; $display("FAIL rec3_addr got=%0d,%0d,%0d want=0,1,2", wr_addr[0], wr_addr[1], wr_addr[2]); end
      n_checks++; if (wr_data[0] !== 32'h1 || wr_data[1] !== 32'h40 || wr_data[2] !== 32'h0) begin n_fail++; $display("FAIL rec3_data got=%h,%h,%h want=1,40,0", wr_data[0], wr_data[1], wr_data[2]); end
    end
    n_checks++; if (length !== 7'd3) begin n_fail++; $display("FAIL rec3_length got=%0d want=3", length); end
    n_checks++; if (recording !== 1'b0 || playing !== 1'b0) begin n_fail++; $display("FAIL rec3_idle got=%b/%b want=0/0", recording, playing); end
  endtask

  task automatic test_play();
    logic [31:0] exp_v [3];
    exp_v[0] = 32'h1; exp_v[1] = 32'h40; exp_v[2] = 32'h0;
    clear_logs();
    mode = 1'b1;
    press_select();
    n_checks++; if (playing !== 1'b1) begin n_fail++; $display("FAIL play_start got=%b want=1", playing); end
    for (int i = 0; i < 3; i++) begin
      beat_tick = 1'b1; cyc(1); beat_tick = 1'b0;
      n_checks++; if (ram_address !== 6'(i)) begin n_fail++; $display("FAIL play_addr%0d got=%0d want=%0d", i, ram_address, i); end
      cyc(4);
      n_checks++; if (nv_data.size() !== i + 1) begin n_fail++; $display("FAIL play_valid%0d got=%0d want=%0d", i, nv_data.size(), i + 1); end
      else begin
        n_checks++; if (nv_data[i] !== exp_v[i]) begin n_fail++; $display("FAIL play_note%0d got=%h want=%h", i, nv_data[i], exp_v[i]); end
      end
    end
`ifdef LOOP_PLAY_EN
    n_checks++; if (playing !== 1'b1) begin n_fail++; $display("FAIL loop_playing got=%b want=1", playing); end
    beat_tick = 1'b1; cyc(1); beat_tick = 1'b0; cyc(4);
    n_checks++; if (nv_data.size() !== 4 || nv_data[nv_data.size()-1] !== 32'h1) begin n_fail++; $display("FAIL loop_wrap got=%0d entries want=4 ending 0x1", nv_data.size()); end
    press_back(); cyc(1);
    n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL loop_stop got=%b want=0", playing); end
`else
    n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL play_end got=%b want=0", playing); end
    beat_tick = 1'b1; cyc(1); beat_tick = 1'b0; cyc(4);
    n_checks++; if (nv_data.size() !== 3) begin n_fail++; $display("FAIL play_onepass got=%0d want=3", nv_data.size()); end
`endif
    n_checks++; if (length !== 7'd3) begin n_fail++; $display("FAIL play_length got=%0d want=3", length); end
  endtask

  task automatic test_intra_or();
    clear_logs();
    start_recording();
    note_in = 32'h2; cyc(1); note_in = 32'h0; cyc(1);
    note_in = 32'h1000; cyc(1); note_in = 32'h0; cyc(1);
    beat_tick = 1'b1; cyc(1); beat_tick = 1'b0;
    press_select(); cyc(3);
    n_checks++; if (wr_data.size() !== 1 || wr_data[0] !== 32'h1002) begin n_fail++; $display("FAIL intra_or got=%0d words first=%h want=1 word 0x1002", wr_data.size(), (wr_data.size() > 0) ? wr_data[0] : 32'hx); end
    n_checks++; if (length !== 7'd1) begin n_fail++; $display("FAIL intra_len got=%0d want=1", length); end
  endtask

  task automatic test_full();
    clear_logs();
    start_recording();
    for (int i = 0; i < 64; i++) beat(32'h100 + 32'(i));
    note_in = 32'd0; cyc(3);
    n_checks++; if (wr_addr.size() !== 64) begin n_fail++; $display("FAIL full_count got=%0d want=64", wr_addr.size()); end
    else begin
      n_checks++; if (wr_addr[63] !== 6'd63 || wr_data[63] !== 32'h13F) begin n_fail++; $display("FAIL full_last got=%0d/%h want=63/13f", wr_addr[63], wr_data[63]); end
    end
    n_checks++; if (length !== 7'd64) begin n_fail++; $display("FAIL full_len got=%0d want=64", length); end
    n_checks++; if (recording !== 1'b0) begin n_fail++; $display("FAIL full_idle got=%b want=0", recording); end
    beat(32'h5); note_in = 32'd0; cyc(3);
    n_checks++; if (wr_addr.size() !== 64) begin n_fail++; $display("FAIL full_extra got=%0d want=64", wr_addr.size()); end
  endtask

  task automatic test_simultaneous();
    clear_logs();
    start_recording();
    beat(32'h5);
    note_in = 32'd0; cyc(2);
    back = 1'b1; beat_tick = 1'b1; cyc(1);
    back = 1'b0; beat_tick = 1'b0; cyc(3);
    n_checks++; if (wr_addr.size() !== 1) begin n_fail++; $display("FAIL back_tick_writes got=%0d want=1", wr_addr.size()); end
    n_checks++; if (length !== 7'd0 || recording !== 1'b0) begin n_fail++; $display("FAIL back_tick_state got=%0d/%b want=0/0", length, recording); end
    clear_logs();
    start_recording();
    beat(32'h7);
    note_in = 32'h9; cyc(2);
    select = 1'b1; beat_tick = 1'b1; cyc(1);
    select = 1'b0; beat_tick = 1'b0; note_in = 32'd0; cyc(3);
    n_checks++; if (wr_addr.size() !== 2 || wr_data[1] !== 32'h9 || wr_addr[1] !== 6'd1) begin n_fail++; $display("FAIL sel_tick_write got=%0d words want=2 (addr1 data 0x9)", wr_addr.size()); end
    n_checks++; if (length !== 7'd2 || recording !== 1'b0) begin n_fail++; $display("FAIL sel_tick_state got=%0d/%b want=2/0", length, recording); end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    start_recording();
    for (int i = 0; i < 5; i++) beat(32'h10 + 32'(i));
    note_in = 32'h3; cyc(2);
    n_checks++; if (length !== 7'd5) begin n_fail++; $display("FAIL mid_len_before got=%0d want=5", length); end
    resetn = 1'b0; #1;
    n_checks++; if (ram_address !== 6'd0 || ram_wren !== 1'b0 || ram_data !== 32'd0 || note_out !== 32'd0 || note_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_outputs got addr=%0d wren=%b data=%h note=%h nv=%b want all 0", ram_address, ram_wren, ram_data, note_out, note_valid); end
    n_checks++; if (length !== 7'd0 || recording !== 1'b0 || playing !== 1'b0) begin n_fail++; $display("FAIL mid_reset_status got=%0d/%b/%b want=0/0/0", length, recording, playing); end
    note_in = 32'd0; cyc(2);
    resetn = 1'b1; cyc(2);
    mode = 1'b1;
    press_select(); cyc(2);
    n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL mid_play_empty got=%b want=0", playing); end
  endtask

  initial begin
    test_reset();
    test_record3();
    test_play();
    test_intra_or();
    test_full();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
